// File: rtl/tc_timer_pkg.sv
// Shared definitions for the tc_timer peripheral: FSM state codes, CTRL bit
// positions, register offsets and the TC1/TC2 window bases (the same constants
// the MEM-stage load extender range-checks).
package tc_timer_pkg;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // CTRL register layout: {[4+]PSC (prescale build only), [3]IM, [2:1]MODE, [0]EN}
  localparam int TC_CTRL_EN       = 0;
  localparam int TC_CTRL_MODE_LSB = 1;
  localparam int TC_CTRL_IM       = 3;
  localparam int TC_CTRL_PSC_LSB  = 4;
  localparam int TC_CTRL_BASE_W   = 4;

  // MODE encodings; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  // Byte offsets inside the 3-word window
  localparam logic [31:0] TC_OFF_CTRL   = 32'h0000_0000;
  localparam logic [31:0] TC_OFF_PRESET = 32'h0000_0004;
  localparam logic [31:0] TC_OFF_COUNT  = 32'h0000_0008;

  // Window bases of the two timer instances
  localparam logic [31:0] TC1_BASE = 32'h0000_7f00;
  localparam logic [31:0] TC2_BASE = 32'h0000_7f10;

  // Word-aligned byte offset of addr from base; the byte-lane bits are dropped
  // because the peripheral only supplies whole words.
  function automatic logic [31:0] tc_reg_off(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr & 32'hffff_fffc) - base;
  endfunction

endpackage

// File: rtl/tc_timer_if.sv
// Bridge-side bus of one timer window: word write strobe, address, write
// data, combinational read data and the level interrupt request to CP0.
interface tc_timer_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (
    output addr,
    output we,
    output din,
    input  dout,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  din,
    output dout,
    output irq
  );
endinterface

// File: rtl/tc_timer_prescaler.sv
// Decrement divider for tc_timer. Only present when TC_PRESCALE_EN is
// defined; the default build has no divider logic at all.
// Down-counter reloaded with PSC; a tick is issued on the terminal count, so
// an enabled divider ticks once every PSC+1 cycles. Clearing reloads PSC so
// the first tick after a clear lands PSC+1 cycles later.
`ifdef TC_PRESCALE_EN
module tc_prescaler #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] psc_i,
  output logic         tick_o
);

  logic [W-1:0] div_q;

  // Terminal-count compare drives the decrement tick
  assign tick_o = en_i && (div_q == '0);

  // Divider down-counter: reload on clear or terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (clr_i) begin
      div_q <= psc_i;
    end else if (en_i) begin
      if (div_q == '0) begin
        div_q <= psc_i;
      end else begin
        div_q <= div_q - 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped down-counting timer with interrupt request.
// Window: CTRL at +0, PRESET at +4, COUNT at +8 (read-only); other
// addresses read as zero. Read data is combinational (zero latency).
// Optional feature macro: TC_PRESCALE_EN adds a PSC field at CTRL[4 +: PRESCALE_W]
// and a divider so COUNT decrements once every PSC+1 cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// TC_IDLE | stopped; moves to TC_LOAD when EN is set
// TC_LOAD | copy PRESET into COUNT
// TC_CNT  | counting down; EN clear stops with COUNT held
// TC_INT  | expiry: set irq flag; one-shot clears EN, auto-reload relaunches
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = TC1_BASE,
  parameter int          PRESCALE_W = 4
) (
  input  logic   clk,
  input  logic   reset,
  tc_timer_if.slave bus
);

`ifdef TC_PRESCALE_EN
  localparam bit PSC_ON = 1'b1;
`else
  localparam bit PSC_ON = 1'b0;
`endif

  // CTRL only holds the PSC field when the prescaler is built in, so those
  // bits read back as zero and writes to them vanish in the default build.
  localparam int CTRL_W = TC_CTRL_BASE_W + (PSC_ON ? PRESCALE_W : 0);

  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       preset_q;
  logic [31:0]       count_q;
  tc_state_e         state_q;
  logic              irq_flag_q;

  logic [31:0] reg_off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [31:0] rd_data;
  logic        tick;
  logic        ctrl_en;
  logic        mode_reload;

  assign reg_off     = tc_reg_off(bus.addr, BASE_ADDR);
  assign wr_ctrl     = bus.we && (reg_off == TC_OFF_CTRL);
  assign wr_preset   = bus.we && (reg_off == TC_OFF_PRESET);
  assign ctrl_en     = ctrl_q[TC_CTRL_EN];
  assign mode_reload = (ctrl_q[TC_CTRL_MODE_LSB +: 2] == TC_MODE_RELOAD);

  // Zero-latency read mux; COUNT writes are simply not decoded
  always_comb begin
    rd_data = 32'h0;
    case (reg_off)
      TC_OFF_CTRL:   rd_data = {{(32 - CTRL_W){1'b0}}, ctrl_q};
      TC_OFF_PRESET: rd_data = preset_q;
      TC_OFF_COUNT:  rd_data = count_q;
      default:       rd_data = 32'h0;
    endcase
  end

  assign bus.dout = rd_data;
  assign bus.irq  = ctrl_q[TC_CTRL_IM] & irq_flag_q;

`ifdef TC_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_sel;
  logic                  div_clr;
  logic                  div_en;

  // On a CTRL write the divider must pick up the PSC being written, not the old one
  assign psc_sel = wr_ctrl ? bus.din[TC_CTRL_PSC_LSB +: PRESCALE_W]
                           : ctrl_q[TC_CTRL_PSC_LSB +: PRESCALE_W];
  assign div_clr = (state_q == TC_LOAD) || wr_ctrl;
  assign div_en  = (state_q == TC_CNT) && ctrl_en;

  tc_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (div_clr),
    .en_i   (div_en),
    .psc_i  (psc_sel),
    .tick_o (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Register file and sequencing FSM; software writes are applied last so they
  // win over the hardware EN clear and the irq flag set in TC_INT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      state_q    <= TC_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        TC_IDLE: begin
          // Auto-reload flag lives for exactly the cycle after TC_INT
          if (mode_reload) begin
            irq_flag_q <= 1'b0;
          end
          if (ctrl_en) begin
            state_q <= TC_LOAD;
          end
        end
        TC_LOAD: begin
          count_q <= preset_q;
          state_q <= TC_CNT;
        end
        TC_CNT: begin
          if (!ctrl_en) begin
            state_q <= TC_IDLE;
          end else if (tick) begin
            // PRESET of 0 or 1 expires on the first decrement opportunity
            if (count_q > 32'd1) begin
              count_q <= count_q - 32'd1;
            end else begin
              count_q <= 32'h0;
              state_q <= TC_INT;
            end
          end
        end
        TC_INT: begin
          irq_flag_q <= 1'b1;
          state_q    <= TC_IDLE;
          if (!mode_reload) begin
            ctrl_q[TC_CTRL_EN] <= 1'b0;
          end
        end
        default: begin
          state_q <= TC_IDLE;
        end
      endcase

      if (wr_preset) begin
        preset_q <= bus.din;
      end

      if (wr_ctrl) begin
        ctrl_q     <= bus.din[CTRL_W-1:0];
        irq_flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer (TC1 window at 0x7f00). Works for both the
// default build and the TC_PRESCALE_EN build.
module tb_tc_timer;
  import tc_timer_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
  localparam logic [31:0] A_PRESET = 32'h0000_7f04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7f08;

`ifdef TC_PRESCALE_EN
  localparam logic [31:0] CTRL_ALL = 32'h0000_00ff;
`else
  localparam logic [31:0] CTRL_ALL = 32'h0000_000f;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  tc_timer_if bus_if ();

  tc_timer #(
    .BASE_ADDR  (32'h0000_7f00),
    .PRESCALE_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write lands on the next rising edge; returns 1ns after that edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a;
    bus_if.din  = d;
    bus_if.we   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus_if.addr = a;
    #1;
    chk(bus_if.dout, exp, tag);
  endtask

  task automatic chk_state(input tc_state_e exp, input string tag);
    chk(32'(dut.state_q), 32'(exp), tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    bus_if.addr = 32'h0;
    bus_if.we   = 1'b0;
    bus_if.din  = 32'h0;
    reset       = 1'b0;
    #12;
    reset = 1'b1;
    step(1);

    // Reset state
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_PRESET, 32'h0, "rst_preset");
    rd(A_COUNT, 32'h0, "rst_count");
    chk({31'h0, bus_if.irq}, 32'h0, "rst_irq");

    // One-shot, PRESET=3, IM|EN
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    chk_state(TC_IDLE, "os_idle_t0");
    step(1); chk_state(TC_LOAD, "os_load_t1");
    step(1); rd(A_COUNT, 32'd3, "os_cnt3");
    step(1); rd(A_COUNT, 32'd2, "os_cnt2");
    step(1); rd(A_COUNT, 32'd1, "os_cnt1");
    chk({31'h0, bus_if.irq}, 32'h0, "os_irq_t4");
    step(1); rd(A_COUNT, 32'd0, "os_cnt0");
    chk_state(TC_INT, "os_int_t5");
    chk({31'h0, bus_if.irq}, 32'h0, "os_irq_t5");
    step(1); chk({31'h0, bus_if.irq}, 32'h1, "os_irq_t6");
    rd(A_CTRL, 32'h8, "os_en_cleared");
    step(3); chk({31'h0, bus_if.irq}, 32'h1, "os_irq_hold");
    wr(A_CTRL, 32'h0);
    chk({31'h0, bus_if.irq}, 32'h0, "os_irq_cleared");

    // Auto-reload, PRESET=2, period 5
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hb);
    step(2); rd(A_COUNT, 32'd2, "ar_cnt2");
    step(2); rd(A_COUNT, 32'd0, "ar_cnt0");
    chk({31'h0, bus_if.irq}, 32'h0, "ar_irq_t4");
    step(1); chk({31'h0, bus_if.irq}, 32'h1, "ar_pulse1");
    step(1); chk({31'h0, bus_if.irq}, 32'h0, "ar_pulse1_end");
    step(1); rd(A_COUNT, 32'd2, "ar_reload");
    step(3); chk({31'h0, bus_if.irq}, 32'h1, "ar_pulse2");
    step(1); chk({31'h0, bus_if.irq}, 32'h0, "ar_pulse2_end");
    wr(A_CTRL, 32'h0);
    step(2);

    // Masked expiry: flag sets internally, irq stays low
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h1);
    step(4); chk({31'h0, bus_if.irq}, 32'h0, "mask_irq_t4");
    step(1); chk({31'h0, bus_if.irq}, 32'h0, "mask_irq_t5");
    chk({31'h0, dut.irq_flag_q}, 32'h1, "mask_flag_set");
    rd(A_CTRL, 32'h0, "mask_en_cleared");

    // Disable mid-count freezes COUNT at 5
    wr(A_PRESET, 32'd8);
    wr(A_CTRL, 32'h1);
    step(4); rd(A_COUNT, 32'd6, "dis_cnt6");
    wr(A_CTRL, 32'h0);
    rd(A_COUNT, 32'd5, "dis_cnt5");
    step(2); rd(A_COUNT, 32'd5, "dis_hold5");
    chk_state(TC_IDLE, "dis_idle");

    // Bus behaviour
    wr(A_COUNT, 32'h0000_dead);
    rd(A_COUNT, 32'd5, "bus_count_ro");
    rd(32'h0000_7f0c, 32'h0, "bus_off_c");
    rd(32'h0000_7f20, 32'h0, "bus_outside");
    wr(A_CTRL, 32'hffff_ffff);
    rd(A_CTRL, CTRL_ALL, "bus_ctrl_all");
    rd(32'h0000_7f02, CTRL_ALL, "bus_bytelane");
    wr(A_CTRL, 32'h0);
    step(2);

    // PRESET change mid-count takes effect at next LOAD
    wr(A_PRESET, 32'd4);
    wr(A_CTRL, 32'h3);
    step(3); rd(A_COUNT, 32'd3, "pm_cnt3");
    wr(A_PRESET, 32'd6);
    rd(A_COUNT, 32'd2, "pm_undisturbed");
    step(5); rd(A_COUNT, 32'd6, "pm_new_preset");
    wr(A_CTRL, 32'h0);
    step(2);

    // PRESET=0 behaves like PRESET=1
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    step(2); rd(A_COUNT, 32'd0, "p0_cnt");
    chk_state(TC_CNT, "p0_cnt_state");
    step(1); chk_state(TC_INT, "p0_int");
    chk({31'h0, bus_if.irq}, 32'h0, "p0_irq_t3");
    step(1); chk({31'h0, bus_if.irq}, 32'h1, "p0_irq_t4");
    wr(A_CTRL, 32'h0);
    step(1);

    // Software CTRL write in TC_INT wins and suppresses the flag
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h9);
    step(3); chk_state(TC_INT, "sw_int");
    wr(A_CTRL, 32'hb);
    rd(A_CTRL, 32'hb, "sw_ctrl_wins");
    chk({31'h0, bus_if.irq}, 32'h0, "sw_no_irq");
    chk({31'h0, dut.irq_flag_q}, 32'h0, "sw_flag_clear");
    wr(A_CTRL, 32'h0);
    step(3);

`ifdef TC_PRESCALE_EN
    // PSC=1: each COUNT value held two cycles
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h19);
    step(2); rd(A_COUNT, 32'd2, "psc_t2");
    step(1); rd(A_COUNT, 32'd2, "psc_t3");
    step(1); rd(A_COUNT, 32'd1, "psc_t4");
    step(1); rd(A_COUNT, 32'd1, "psc_t5");
    step(1); rd(A_COUNT, 32'd0, "psc_t6");
    chk({31'h0, bus_if.irq}, 32'h0, "psc_irq_t6");
    step(1); chk({31'h0, bus_if.irq}, 32'h1, "psc_irq_t7");
    wr(A_CTRL, 32'h0);
    step(2);
`endif

    // Async reset mid-count at COUNT=7
    wr(A_PRESET, 32'd9);
    wr(A_CTRL, 32'h9);
    step(4); rd(A_COUNT, 32'd7, "ar_pre_cnt7");
    #1;
    reset = 1'b0;
    #1;
    chk(bus_if.dout, 32'h0, "arst_count0");
    chk({31'h0, bus_if.irq}, 32'h0, "arst_irq0");
    chk_state(TC_IDLE, "arst_idle");
    #2;
    reset = 1'b1;
    step(4);
    rd(A_COUNT, 32'h0, "post_rst_count");
    rd(A_PRESET, 32'h0, "post_rst_preset");
    rd(A_CTRL, 32'h0, "post_rst_ctrl");
    chk_state(TC_IDLE, "post_rst_idle");
    chk({31'h0, bus_if.irq}, 32'h0, "post_rst_irq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
